display_scan_ctrl: RTL and testbench

Parametrised successor to the two-digit keypad/display path. It holds an N-digit entry register, shifted on each validated keypad code, and time-multiplexes the digits onto one shared seven-segment decoder. Each slot has a programmable anti-ghosting blank interval and 16-level brightness PWM. It sits between keypad_scanner (key_code/key_valid) and seven_segment (hex_out), and drives the digit power-select pins directly.

---
 rtl/display_pkg.sv | 21 ++
 rtl/display_scan_ctrl_shift.sv | 37 +++
 rtl/display_scan_ctrl.sv | 103 ++++++++++
 tb/tb_display_scan_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed seven-segment display path.
package display_pkg;

    typedef logic [3:0] digit_t;

    localparam digit_t BRIGHT_FULL = 4'hF;
    localparam int     MAX_DIGITS  = 32;

    // All-off select pattern for n digits; bits above n are zero.
    function automatic logic [MAX_DIGITS-1:0] sel_inactive(input int n, input bit active_high);
        logic [MAX_DIGITS-1:0] v;
        v = '0;
        if (!active_high) begin
            for (int i = 0; i < MAX_DIGITS; i++) begin
                if (i < n) v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_shift.sv
// N-digit keypad entry register: newest code enters at digit 0, oldest falls off.
module digit_shift_reg
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    key_valid,
    input  logic [3:0]              key_code,
    output logic [4*NUM_DIGITS-1:0] digits
);

    digit_t                  code;
    logic [4*NUM_DIGITS-1:0] shifted;

    assign code = key_code;

    generate
        if (NUM_DIGITS == 1) begin : g_single
            assign shifted = code;
        end else begin : g_multi
            assign shifted = {digits[4*NUM_DIGITS-5:0], code};
        end
    endgenerate

    // clear wins over a simultaneous key; the key is dropped, not queued
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            digits <= '0;
        end else if (key_valid) begin
            digits <= shifted;
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed N-digit display scanner with anti-ghost blanking and 16-level PWM.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS      = 2,
    parameter int DIGIT_PERIOD    = 60000,
    parameter int BLANK_CYCLES    = 600,
    parameter int SEL_ACTIVE_HIGH = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              key_code,
    input  logic                    key_valid,
    input  logic                    clear,
    input  logic [3:0]              brightness,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic [3:0]              hex_out,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    slot_start
);

    localparam int CNT_W = $clog2(DIGIT_PERIOD);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [MAX_DIGITS-1:0] SEL_OFF_ALL = sel_inactive(NUM_DIGITS, SEL_ACTIVE_HIGH != 0);
    localparam logic [NUM_DIGITS-1:0] SEL_OFF     = SEL_OFF_ALL[NUM_DIGITS-1:0];
    localparam logic [CNT_W-1:0]      CNT_LAST    = CNT_W'(DIGIT_PERIOD - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST    = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        cnt_p0;
    logic [IDX_W-1:0]        idx_p0;
    logic [4*NUM_DIGITS-1:0] digits_p0;
    logic [3:0]              pwm_phase;
    logic                    in_on;
    logic                    lit;
    logic [NUM_DIGITS-1:0]   sel_nxt;
    logic [3:0]              hex_nxt;
    logic                    start_nxt;

    digit_shift_reg #(
        .NUM_DIGITS(NUM_DIGITS)
    ) u_shift (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .key_valid(key_valid),
        .key_code (key_code),
        .digits   (digits_p0)
    );

    assign digits = digits_p0;

    // ---- stage p0: slot counter and digit index ----
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_p0 <= '0;
            idx_p0 <= '0;
        end else if (cnt_p0 == CNT_LAST) begin
            cnt_p0 <= '0;
            idx_p0 <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + 1'b1;
        end else begin
            cnt_p0 <= cnt_p0 + 1'b1;
        end
    end

    generate
        if (CNT_W >= 4) begin : g_phase_wide
            assign pwm_phase = cnt_p0[3:0];
        end else begin : g_phase_narrow
            assign pwm_phase = 4'(cnt_p0);
        end

        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign in_on = 1'b1;
        end else begin : g_blank
            assign in_on = (cnt_p0 >= CNT_W'(BLANK_CYCLES));
        end
    endgenerate

    assign lit = in_on && ((brightness == BRIGHT_FULL) || (pwm_phase <= brightness));

    // Only the scanned digit's bit ever leaves the off pattern, so selects stay one-hot.
    always_comb begin
        sel_nxt = SEL_OFF;
        if (lit) sel_nxt[idx_p0] = ~SEL_OFF[idx_p0];
        hex_nxt   = digits_p0[{idx_p0, 2'b00} +: 4];
        start_nxt = (cnt_p0 == '0);
    end

    // ---- stage p1: registered pin outputs ----
    always_ff @(posedge clk) begin
        if (reset) begin
            digit_sel  <= SEL_OFF;
            hex_out    <= '0;
            slot_start <= 1'b0;
        end else begin
            digit_sel  <= sel_nxt;
            hex_out    <= hex_nxt;
            slot_start <= start_nxt;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench: two display_scan_ctrl configurations against a slot-arithmetic reference model.
module tb_display_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, key_valid, clear;
    logic [3:0] key_code, brightness;

    logic [3:0]  sel4, hex4, hex1, dig1;
    logic [15:0] dig4;
    logic [0:0]  sel1;
    logic        slot4, slot1;

    display_scan_ctrl #(
        .NUM_DIGITS(4), .DIGIT_PERIOD(40), .BLANK_CYCLES(8), .SEL_ACTIVE_HIGH(1)
    ) dut4 (
        .clk(clk), .reset(reset), .key_code(key_code), .key_valid(key_valid),
        .clear(clear), .brightness(brightness), .digit_sel(sel4), .hex_out(hex4),
        .digits(dig4), .slot_start(slot4)
    );

    display_scan_ctrl #(
        .NUM_DIGITS(1), .DIGIT_PERIOD(20), .BLANK_CYCLES(0), .SEL_ACTIVE_HIGH(0)
    ) dut1 (
        .clk(clk), .reset(reset), .key_code(key_code), .key_valid(key_valid),
        .clear(clear), .brightness(brightness), .digit_sel(sel1), .hex_out(hex1),
        .digits(dig1), .slot_start(slot1)
    );

    typedef struct packed {
        logic [3:0]  sel;
        logic [3:0]  hex;
        logic        start;
        logic [15:0] digits;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_vec = 0;
    int n_err = 0;

    int cfg_n[2]  = '{4, 1};
    int cfg_p[2]  = '{40, 20};
    int cfg_b[2]  = '{8, 0};
    bit cfg_ah[2] = '{1'b1, 1'b0};

    // Model state: cycles elapsed since reset, and the displayed digits (index 0 = newest).
    int         m_t[2];
    logic [3:0] md[2][4];

    function automatic exp_t model(input int d);
        exp_t       e;
        int         n, p, cnt, idx;
        logic [3:0] off;
        n   = cfg_n[d];
        p   = cfg_p[d];
        off = cfg_ah[d] ? 4'h0 : 4'((1 << n) - 1);
        e   = '0;
        if (reset) begin
            e.sel  = off;
            m_t[d] = 0;
            for (int i = 0; i < 4; i++) md[d][i] = 4'h0;
            return e;
        end
        cnt     = m_t[d] % p;
        idx     = (m_t[d] / p) % n;
        e.sel   = off;
        if (cnt >= cfg_b[d] && (cnt % 16) <= int'(brightness)) e.sel[idx] = ~off[idx];
        e.hex   = md[d][idx];
        e.start = (cnt == 0);
        m_t[d]  = m_t[d] + 1;
        if (clear) begin
            for (int i = 0; i < 4; i++) md[d][i] = 4'h0;
        end else if (key_valid) begin
            for (int i = n - 1; i > 0; i--) md[d][i] = md[d][i-1];
            md[d][0] = key_code;
        end
        for (int i = 0; i < n; i++) e.digits = e.digits | ({12'h0, md[d][i]} << (4 * i));
        return e;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cycle();
        q0.push_back(model(0));
        q1.push_back(model(1));
        @(negedge clk);
    endtask

    // Monitor: every output update is checked against the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() != 0) begin
                e = q0.pop_front();
                chk("dut4.digit_sel", 16'(sel4), 16'(e.sel));
                chk("dut4.hex_out", 16'(hex4), 16'(e.hex));
                chk("dut4.slot_start", 16'(slot4), 16'(e.start));
                chk("dut4.digits", dig4, e.digits);
                chk("dut4.onehot", 16'($countones(sel4) <= 1), 16'd1);
            end
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("dut1.digit_sel", 16'(sel1), 16'(e.sel));
                chk("dut1.hex_out", 16'(hex1), 16'(e.hex));
                chk("dut1.slot_start", 16'(slot1), 16'(e.start));
                chk("dut1.digits", 16'(dig1), e.digits);
            end
        end
    end

    initial begin
        int guard;
        reset      = 1'b1;
        clear      = 1'b0;
        key_valid  = 1'b0;
        key_code   = 4'h0;
        brightness = 4'hF;
        repeat (3) cycle();
        reset = 1'b0;

        for (int k = 1; k <= 5; k++) begin
            key_valid = 1'b1; key_code = 4'(k); cycle();
            key_valid = 1'b0; cycle();
        end
        clear = 1'b1; key_valid = 1'b1; key_code = 4'h7; cycle();
        clear = 1'b0; key_valid = 1'b0; cycle();
        for (int k = 2; k <= 5; k++) begin
            key_valid = 1'b1; key_code = 4'(k); cycle();
            key_valid = 1'b0;
        end

        repeat (170) cycle();
        brightness = 4'h3; repeat (80) cycle();
        brightness = 4'h0; repeat (80) cycle();
        brightness = 4'hF;

        guard = 0;
        while (!(((m_t[0] / 40) % 4 == 2) && (m_t[0] % 40 == 20)) && guard < 400) begin
            cycle();
            guard++;
        end
        reset = 1'b1; cycle();
        reset = 1'b0; repeat (100) cycle();

        repeat (1500) begin
            key_valid = ($urandom_range(0, 5) == 0);
            key_code  = 4'($urandom);
            clear     = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 30) == 0) brightness = 4'($urandom);
            reset     = ($urandom_range(0, 400) == 0);
            cycle();
        end
        reset = 1'b0; clear = 1'b0; key_valid = 1'b0;
        cycle();

        @(posedge clk);
        #2;
        chk("drain.q0", 16'(q0.size()), 16'd0);
        chk("drain.q1", 16'(q1.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
